// File: rtl/pll_lock_reset_seq.sv
// PLL reset/lock sequencer: drives the PLL reset, filters lock glitches,
// and produces a qualified system reset and ready flag.
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int CNT_W               = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic             sys_rst,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] loss_count
);

  localparam int MAX_RF =
    (PLL_RST_CYCLES > LOCK_FILTER_CYCLES) ?
    PLL_RST_CYCLES : LOCK_FILTER_CYCLES;
  localparam int MAX_C =
    (MAX_RF > LOCK_TIMEOUT_CYCLES) ?
    MAX_RF : LOCK_TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] L_RST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] L_FILT = CW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CW-1:0] L_TO   = CW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST = 2'd0,
    S_WAIT    = 2'd1,
    S_FILTER  = 2'd2,
    S_RUN     = 2'd3
  } state_e;

  state_e                 r_state;
  state_e                 w_next;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  logic                   w_retry_inc;
  logic                   w_loss_inc;
  logic                   r_pll_reset;
  logic                   r_sys_rst;
  logic                   r_ready;
  logic [CNT_W-1:0]       r_retry;
  logic [CNT_W-1:0]       r_loss;

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt + CW'(1);
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    unique case (r_state)
      S_PLL_RST: begin
        if (r_cnt == L_RST) w_next = S_WAIT;
      end
      S_WAIT: begin
        // a lock arriving on the timeout cycle takes precedence
        if (w_lock_s) begin
          w_next = S_FILTER;
        end else if (r_cnt == L_TO) begin
          w_next      = S_PLL_RST;
          w_retry_inc = 1'b1;
        end
      end
      S_FILTER: begin
        if (!w_lock_s) w_next = S_WAIT;
        else if (r_cnt == L_FILT) w_next = S_RUN;
      end
      S_RUN: begin
        w_cnt_next = '0;
        if (!w_lock_s) begin
          w_next     = S_WAIT;
          w_loss_inc = 1'b1;
        end
      end
      default: w_next = S_PLL_RST;
    endcase
    if (w_next != r_state) w_cnt_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_PLL_RST;
      r_cnt       <= '0;
      r_sync      <= '0;
      r_pll_reset <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_retry     <= '0;
      r_loss      <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_sync      <= {r_sync[SYNC_STAGES-2:0], pll_lock};
      // outputs decoded from next state so they move with the state reg
      r_pll_reset <= (w_next == S_PLL_RST);
      r_sys_rst   <= (w_next != S_RUN);
      r_ready     <= (w_next == S_RUN);
      if (w_retry_inc && !(&r_retry)) r_retry <= r_retry + CNT_W'(1);
      if (w_loss_inc && !(&r_loss)) r_loss <= r_loss + CNT_W'(1);
    end
  end

  assign pll_reset   = r_pll_reset;
  assign sys_rst     = r_sys_rst;
  assign ready       = r_ready;
  assign state       = r_state;
  assign retry_count = r_retry;
  assign loss_count  = r_loss;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Scoreboard bench for pll_lock_reset_seq: directed lock waveforms,
// expected output snapshots queued by cycle and checked by a monitor.
module tb_pll_lock_reset_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic       sys_rst;
  logic       ready;
  logic [1:0] state;
  logic [7:0] retry_count;
  logic [7:0] loss_count;

  pll_lock_reset_seq #(
    .SYNC_STAGES(2),
    .PLL_RST_CYCLES(4),
    .LOCK_FILTER_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(20),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_lock(pll_lock),
    .pll_reset(pll_reset),
    .sys_rst(sys_rst),
    .ready(ready),
    .state(state),
    .retry_count(retry_count),
    .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    string       nm;
    logic [1:0]  st;
    logic [7:0]  rc;
    logic [7:0]  lc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned base = 0;
  int          n_checks = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_at(input int k, input string nm,
                        input logic [1:0] st, input int rc,
                        input int lc);
    exp_t e;
    e.cyc = base + k;
    e.nm  = nm;
    e.st  = st;
    e.rc  = rc[7:0];
    e.lc  = lc[7:0];
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  // reset edge is the next posedge; cycle 1 follows it
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pll_lock = 1'b0;
    base = cyc;
    exp_at(1, "reset_vals", 2'd0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: sample 1 time unit after each edge
  initial begin
    exp_t e;
    logic want_pr;
    logic want_sr;
    logic want_rdy;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        want_pr  = (e.st == 2'd0);
        want_sr  = (e.st != 2'd3);
        want_rdy = (e.st == 2'd3);
        n_checks++;
        if (e.cyc != cyc || state !== e.st ||
            pll_reset !== want_pr || sys_rst !== want_sr ||
            ready !== want_rdy || retry_count !== e.rc ||
            loss_count !== e.lc) begin
          n_err++;
          $display({"FAIL %s @cyc %0d (due %0d): got st=%0d prst=%0b ",
                    "srst=%0b rdy=%0b retry=%0d loss=%0d; want st=%0d ",
                    "prst=%0b srst=%0b rdy=%0b retry=%0d loss=%0d"},
                   e.nm, cyc, e.cyc, state, pll_reset, sys_rst, ready,
                   retry_count, loss_count, e.st, want_pr, want_sr,
                   want_rdy, e.rc, e.lc);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);

    // clean start
    do_reset();
    exp_at(2,  "s1_prst_c2",   2'd0, 0, 0);
    exp_at(4,  "s1_prst_c4",   2'd0, 0, 0);
    exp_at(5,  "s1_wait",      2'd1, 0, 0);
    exp_at(12, "s1_prefilter", 2'd1, 0, 0);
    exp_at(13, "s1_filter",    2'd2, 0, 0);
    exp_at(20, "s1_filt_end",  2'd2, 0, 0);
    exp_at(21, "s1_run",       2'd3, 0, 0);
    wait_cyc(10);
    pll_lock = 1'b1;
    wait_cyc(25);

    // loss in RUN
    exp_at(32, "s4_pre_loss", 2'd3, 0, 0);
    exp_at(33, "s4_loss",     2'd1, 0, 1);
    exp_at(35, "s4_wait",     2'd1, 0, 1);
    exp_at(36, "s4_refilter", 2'd2, 0, 1);
    exp_at(43, "s4_filt_end", 2'd2, 0, 1);
    exp_at(44, "s4_rerun",    2'd3, 0, 1);
    wait_cyc(30);
    pll_lock = 1'b0;
    wait_cyc(33);
    pll_lock = 1'b1;
    wait_cyc(46);

    // reset while in RUN
    do_reset();
    exp_at(4, "s6a_prst_c4", 2'd0, 0, 0);
    exp_at(5, "s6a_wait",    2'd1, 0, 0);
    wait_cyc(6);

    // one-cycle glitch during FILTER
    do_reset();
    exp_at(19, "s3_in_filter", 2'd2, 0, 0);
    exp_at(20, "s3_glitch",    2'd1, 0, 0);
    exp_at(21, "s3_refilter",  2'd2, 0, 0);
    exp_at(28, "s3_filt_end",  2'd2, 0, 0);
    exp_at(29, "s3_run",       2'd3, 0, 0);
    wait_cyc(10);
    pll_lock = 1'b1;
    wait_cyc(17);
    pll_lock = 1'b0;
    wait_cyc(18);
    pll_lock = 1'b1;
    wait_cyc(30);

    // lock arriving on the timeout cycle
    do_reset();
    exp_at(23, "s5_wait_c19", 2'd1, 0, 0);
    exp_at(24, "s5_wait_c20", 2'd1, 0, 0);
    exp_at(25, "s5_collide",  2'd2, 0, 0);
    wait_cyc(22);
    pll_lock = 1'b1;
    wait_cyc(26);

    // repeated timeouts and saturation
    do_reset();
    exp_at(24,   "s2_wait_last", 2'd1, 0,   0);
    exp_at(25,   "s2_retry1",    2'd0, 1,   0);
    exp_at(28,   "s2_prst_c4",   2'd0, 1,   0);
    exp_at(29,   "s2_rewait",    2'd1, 1,   0);
    exp_at(301,  "s2_300cyc",    2'd1, 12,  0);
    exp_at(312,  "s2_wait_12",   2'd1, 12,  0);
    exp_at(313,  "s2_retry13",   2'd0, 13,  0);
    exp_at(6120, "s2_pre_sat",   2'd1, 254, 0);
    exp_at(6121, "s2_sat",       2'd0, 255, 0);
    exp_at(6144, "s2_sat_wait",  2'd1, 255, 0);
    exp_at(6145, "s2_no_wrap",   2'd0, 255, 0);
    wait_cyc(6146);

    // reset from saturated counters, then again in PLL_RST cycle 2
    do_reset();
    do_reset();
    exp_at(2, "s6b_prst_c2", 2'd0, 0, 0);
    exp_at(4, "s6b_prst_c4", 2'd0, 0, 0);
    exp_at(5, "s6b_wait",    2'd1, 0, 0);
    wait_cyc(6);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expectations unchecked, want 0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
